// File: rtl/avalon_st_pkg.sv
// Shared constants for the Avalon-ST ready-latency adapter: latency bound, payload bit layout and clog2.
package avalon_st_pkg;

  localparam int MAX_RL   = 4;
  localparam int EOP_BIT  = 0;
  localparam int SOP_BIT  = 1;
  localparam int DATA_LSB = 2;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/avalon_st_ready_latency_adapter_if.sv
// One Avalon-ST link; master drives valid/payload, slave drives ready.
interface avalon_st_ready_latency_adapter_if #(
  parameter int DATA_W = 24
);
  logic              ready;
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              startofpacket;
  logic              endofpacket;

  modport master (input ready, output valid, data, startofpacket, endofpacket);
  modport slave  (output ready, input valid, data, startofpacket, endofpacket);
endinterface

// File: rtl/avalon_st_sync_fifo.sv
// Registered FIFO, head visible one cycle after push; no internal flow control,
// the caller never pushes when full nor pops when empty.
module avalon_st_sync_fifo
  import avalon_st_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] level
);
  localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   level <= level + CNT_W'(1);
        2'b01:   level <= level - CNT_W'(1);
        default: level <= level;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/avalon_st_ready_latency_adapter.sv
// Bridges an IN_RL ready-latency sink to an OUT_RL source through a credit-guarded FIFO;
// in_ready reserves room for every beat already granted, so the FIFO cannot overflow.
module avalon_st_ready_latency_adapter
  import avalon_st_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int IN_RL  = 1,
  parameter int OUT_RL = 0,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = clog2(DEPTH + 1)
) (
  input  logic                              clk,
  input  logic                              reset_n,
  avalon_st_ready_latency_adapter_if.slave  in_st,
  avalon_st_ready_latency_adapter_if.master out_st,
  output logic [CNT_W-1:0]                  fill_level,
  output logic                              overflow_err
);
  localparam int PW    = DATA_W + 2;
  localparam int SUM_W = CNT_W + 3;

  if (IN_RL < 0 || IN_RL > MAX_RL) begin : g_bad_in_rl
    $error("IN_RL out of range 0..%0d", MAX_RL);
  end
  if (OUT_RL < 0 || OUT_RL > MAX_RL) begin : g_bad_out_rl
    $error("OUT_RL out of range 0..%0d", MAX_RL);
  end
  if (DEPTH < IN_RL + 1 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of 2 and at least IN_RL+1");
  end

  logic             run;
  logic             in_ready;
  logic             push;
  logic             pop;
  logic             bad_beat;
  logic             odly;
  logic             out_valid;
  logic [SUM_W-1:0] in_flight;
  logic [PW-1:0]    wr_payload;
  logic [PW-1:0]    head;
  logic [CNT_W-1:0] level;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) run <= 1'b0;
    else          run <= 1'b1;
  end

  // Same-cycle pops are deliberately ignored: the credit check stays a pure register function.
  assign in_ready = run && ((SUM_W'(level) + in_flight) < SUM_W'(DEPTH));

  if (IN_RL == 0) begin : g_in_rl0
    assign in_flight = '0;
    assign push      = in_st.valid && in_ready;
    assign bad_beat  = 1'b0;
  end else begin : g_in_rl
    logic [IN_RL-1:0] gline;
    logic             grant;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        gline <= '0;
      end else begin
        gline[0] <= in_ready;
        for (int i = 1; i < IN_RL; i++) gline[i] <= gline[i-1];
      end
    end

    always_comb begin
      in_flight = '0;
      for (int i = 0; i < IN_RL; i++) in_flight = in_flight + SUM_W'(gline[i]);
    end

    assign grant    = gline[IN_RL-1];
    assign push     = in_st.valid && grant;
    assign bad_beat = in_st.valid && !grant;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      overflow_err <= 1'b0;
    else if (bad_beat) overflow_err <= 1'b1;
  end

  if (OUT_RL == 0) begin : g_out_rl0
    assign odly = 1'b1;
    assign pop  = out_valid && out_st.ready;
  end else begin : g_out_rl
    logic [OUT_RL-1:0] oline;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        oline <= '0;
      end else begin
        oline[0] <= out_st.ready;
        for (int i = 1; i < OUT_RL; i++) oline[i] <= oline[i-1];
      end
    end

    // A delayed ready is a commitment from downstream, so every valid beat is consumed.
    assign odly = oline[OUT_RL-1];
    assign pop  = out_valid;
  end

  assign out_valid = run && (level != '0) && odly;

  always_comb begin
    wr_payload                     = '0;
    wr_payload[EOP_BIT]            = in_st.endofpacket;
    wr_payload[SOP_BIT]            = in_st.startofpacket;
    wr_payload[DATA_LSB +: DATA_W] = in_st.data;
  end

  avalon_st_sync_fifo #(
    .WIDTH (PW),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_payload),
    .head    (head),
    .level   (level)
  );

  assign in_st.ready          = in_ready;
  assign out_st.valid         = out_valid;
  assign out_st.data          = head[DATA_LSB +: DATA_W];
  assign out_st.startofpacket = head[SOP_BIT];
  assign out_st.endofpacket   = head[EOP_BIT];
  assign fill_level           = level;

endmodule

// File: tb/tb_avalon_st_ready_latency_adapter.sv
// Three adapter configurations driven by random traffic and scored against a queue-based model.
module tb_avalon_st_ready_latency_adapter;
  localparam int NI = 3;
  localparam int DW = 24;
  localparam int IRL [NI] = '{1, 2, 0};
  localparam int ORL [NI] = '{0, 2, 0};
  localparam int DEP [NI] = '{4, 8, 2};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic             drv_vld [NI];
  logic             drv_rdy [NI];
  logic [DW+1:0]    drv_pl  [NI];
  logic [NI-1:0]    obs_rdy;
  logic [NI-1:0]    obs_vld;
  logic [NI-1:0]    obs_ovf;
  logic [3:0]       obs_fill [NI];
  logic [DW+1:0]    obs_pl   [NI];

  for (genvar k = 0; k < NI; k++) begin : g_dut
    avalon_st_ready_latency_adapter_if #(.DATA_W(DW)) in_if ();
    avalon_st_ready_latency_adapter_if #(.DATA_W(DW)) out_if ();

    assign in_if.valid         = drv_vld[k];
    assign in_if.data          = drv_pl[k][DW+1:2];
    assign in_if.startofpacket = drv_pl[k][1];
    assign in_if.endofpacket   = drv_pl[k][0];
    assign out_if.ready        = drv_rdy[k];
    assign obs_rdy[k]          = in_if.ready;
    assign obs_vld[k]          = out_if.valid;
    assign obs_pl[k]           = {out_if.data, out_if.startofpacket, out_if.endofpacket};

    avalon_st_ready_latency_adapter #(
      .DATA_W (DW),
      .IN_RL  (IRL[k]),
      .OUT_RL (ORL[k]),
      .DEPTH  (DEP[k]),
      .CNT_W  (4)
    ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .in_st        (in_if),
      .out_st       (out_if),
      .fill_level   (obs_fill[k]),
      .overflow_err (obs_ovf[k])
    );
  end

  int n_chk = 0;
  int n_bad = 0;

  // Model: stored beats, past in_ready / out_ready values, run and sticky error flags.
  logic [DW+1:0] mq [NI][$];
  bit            rh [NI][$];
  bit            oh [NI][$];
  bit            m_run [NI];
  bit            m_ovf [NI];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      mq[k].delete();
      rh[k].delete();
      oh[k].delete();
      for (int i = 0; i < IRL[k]; i++) rh[k].push_back(1'b0);
      for (int i = 0; i < ORL[k]; i++) oh[k].push_back(1'b0);
      m_run[k] = 1'b0;
      m_ovf[k] = 1'b0;
    end
  endtask

  // Called at a falling edge: score the current cycle, drive the next inputs, advance the model.
  task automatic step(input int pv, input int pr, input bit viol);
    int            inflight;
    bit            er, grant, od, ev, v, r;
    logic [DW+1:0] pl;
    for (int k = 0; k < NI; k++) begin
      inflight = 0;
      for (int i = 0; i < rh[k].size(); i++) inflight += int'(rh[k][i]);
      er    = m_run[k] && ((mq[k].size() + inflight) < DEP[k]);
      grant = (IRL[k] == 0) ? er : rh[k][0];
      od    = (ORL[k] == 0) ? 1'b1 : oh[k][0];
      ev    = (mq[k].size() != 0) && od;

      chk($sformatf("u%0d.in_ready", k),     32'(obs_rdy[k]),  32'(er));
      chk($sformatf("u%0d.out_valid", k),    32'(obs_vld[k]),  32'(ev));
      chk($sformatf("u%0d.fill_level", k),   32'(obs_fill[k]), 32'(mq[k].size()));
      chk($sformatf("u%0d.overflow_err", k), 32'(obs_ovf[k]),  32'(m_ovf[k]));
      if (ev) chk($sformatf("u%0d.payload", k), 32'(obs_pl[k]), 32'(mq[k][0]));

      v  = grant ? (int'($urandom_range(99)) < pv) : (viol && ($urandom_range(15) == 0));
      r  = int'($urandom_range(99)) < pr;
      pl = (DW+2)'($urandom);
      drv_vld[k] = v;
      drv_rdy[k] = r;
      drv_pl[k]  = pl;

      if (ev && (ORL[k] > 0 || r)) void'(mq[k].pop_front());
      if (v && grant) mq[k].push_back(pl);
      if (IRL[k] > 0 && v && !grant) m_ovf[k] = 1'b1;
      if (IRL[k] > 0) begin
        rh[k].push_back(er);
        void'(rh[k].pop_front());
      end
      if (ORL[k] > 0) begin
        oh[k].push_back(r);
        void'(oh[k].pop_front());
      end
      m_run[k] = 1'b1;
    end
  endtask

  task automatic run_seg(input int n, input int pv, input int pr, input bit viol);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      step(pv, pr, viol);
    end
  endtask

  // Reset must blank the outputs immediately, then the release cycle keeps in_ready low.
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      drv_vld[k] = 1'b0;
      drv_rdy[k] = 1'b0;
      drv_pl[k]  = '0;
    end
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("u%0d.rst_in_ready", k),  32'(obs_rdy[k]),  32'd0);
      chk($sformatf("u%0d.rst_out_valid", k), 32'(obs_vld[k]),  32'd0);
      chk($sformatf("u%0d.rst_fill", k),      32'(obs_fill[k]), 32'd0);
      chk($sformatf("u%0d.rst_ovf", k),       32'(obs_ovf[k]),  32'd0);
    end
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    step(0, 100, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      drv_vld[k] = 1'b0;
      drv_rdy[k] = 1'b0;
      drv_pl[k]  = '0;
    end
    do_reset();
    run_seg(300, 100, 100, 1'b0);
    run_seg(40,  100,   0, 1'b0);
    run_seg(300,  70,  60, 1'b0);
    run_seg(10,  100,  20, 1'b0);
    do_reset();
    run_seg(200,  80,  50, 1'b1);
    run_seg(50,   50,  50, 1'b0);
    do_reset();
    run_seg(200,  90,  90, 1'b0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
